// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ALU ops until operands arrive,
// then issues the oldest ready op and registers its tagged result.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             dispatch_valid_i,
  output logic             dispatch_ready_o,
  input  logic [31:0]      dispatch_pc_i,
  input  logic [31:0]      dispatch_inst_i,
  input  logic [TAG_W-1:0] dispatch_tag_i,
  input  logic             rs1_ready_i,
  input  logic             rs2_ready_i,
  input  logic [TAG_W-1:0] rs1_tag_i,
  input  logic [TAG_W-1:0] rs2_tag_i,
  input  logic [31:0]      rs1_value_i,
  input  logic [31:0]      rs2_value_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  output logic             alu_request_o,
  output logic [31:0]      alu_pc_o,
  output logic [31:0]      alu_inst_o,
  output logic [31:0]      alu_rs1_value_o,
  output logic [31:0]      alu_rs2_value_o,
  input  logic             alu_writeback_valid_i,
  input  logic [31:0]      alu_writeback_value_i,
  output logic             result_valid_o,
  output logic [TAG_W-1:0] result_tag_o,
  output logic [31:0]      result_value_o,
  input  logic             result_ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_val;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_val;
    logic [AW-1:0]    age;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [CW-1:0] occ;
  logic [AW-1:0] free_idx;
  logic [AW-1:0] sel_idx;
  logic [AW-1:0] sel_age;
  logic          free_found;
  logic          sel_found;
  logic          issue;
  logic          dispatch_fire;
  logic          byp1;
  logic          byp2;

  // age is the count of older valid entries; 0 is the oldest
  always_comb begin
    occ        = '0;
    free_idx   = '0;
    free_found = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    sel_found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CW'(ent_q[i].valid);
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
      if (ent_q[i].valid && ent_q[i].rs1_rdy &&
          ent_q[i].rs2_rdy &&
          (!sel_found || ent_q[i].age < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
        sel_age   = ent_q[i].age;
      end
    end
  end

  assign dispatch_ready_o = occ < CW'(DEPTH);
  assign issue = sel_found && !flush_i &&
                 (!result_valid_o || result_ready_i);
  assign dispatch_fire = dispatch_valid_i &&
                         dispatch_ready_o && !flush_i;
  assign byp1 = cdb_valid_i && cdb_tag_i == rs1_tag_i;
  assign byp2 = cdb_valid_i && cdb_tag_i == rs2_tag_i;

  always_comb begin
    alu_request_o   = 1'b0;
    alu_pc_o        = '0;
    alu_inst_o      = '0;
    alu_rs1_value_o = '0;
    alu_rs2_value_o = '0;
    if (issue) begin
      alu_request_o   = 1'b1;
      alu_pc_o        = ent_q[sel_idx].pc;
      alu_inst_o      = ent_q[sel_idx].inst;
      alu_rs1_value_o = ent_q[sel_idx].rs1_val;
      alu_rs2_value_o = ent_q[sel_idx].rs2_val;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid_i && ent_q[i].valid) begin
        if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_tag_i) begin
          ent_d[i].rs1_rdy = 1'b1;
          ent_d[i].rs1_val = cdb_value_i;
        end
        if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_tag_i) begin
          ent_d[i].rs2_rdy = 1'b1;
          ent_d[i].rs2_val = cdb_value_i;
        end
      end
      if (issue) begin
        if (AW'(i) == sel_idx)
          ent_d[i].valid = 1'b0;
        else if (ent_q[i].age > sel_age)
          ent_d[i].age = ent_q[i].age - 1'b1;
      end
    end
    if (dispatch_fire) begin
      ent_d[free_idx].valid   = 1'b1;
      ent_d[free_idx].pc      = dispatch_pc_i;
      ent_d[free_idx].inst    = dispatch_inst_i;
      ent_d[free_idx].tag     = dispatch_tag_i;
      ent_d[free_idx].rs1_rdy = rs1_ready_i || byp1;
      ent_d[free_idx].rs1_tag = rs1_tag_i;
      ent_d[free_idx].rs1_val = rs1_ready_i ? rs1_value_i : cdb_value_i;
      ent_d[free_idx].rs2_rdy = rs2_ready_i || byp2;
      ent_d[free_idx].rs2_tag = rs2_tag_i;
      ent_d[free_idx].rs2_val = rs2_ready_i ? rs2_value_i : cdb_value_i;
      ent_d[free_idx].age     = AW'(occ - CW'(issue));
    end
    if (flush_i)
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      result_valid_o <= 1'b0;
      result_tag_o   <= '0;
      result_value_o <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      if (flush_i) begin
        result_valid_o <= 1'b0;
      end else if (issue) begin
        result_valid_o <= 1'b1;
        result_tag_o   <= ent_q[sel_idx].tag;
        result_value_o <= alu_writeback_value_i;
      end else if (result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end

  // the arithmetic unit must answer in the issue cycle
  a_wb_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
    alu_request_o |-> alu_writeback_valid_i);

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic
// checked against an age-ordered queue model.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        dispatch_valid_i;
  logic        dispatch_ready_o;
  logic [31:0] dispatch_pc_i, dispatch_inst_i;
  logic [3:0]  dispatch_tag_i;
  logic        rs1_ready_i, rs2_ready_i;
  logic [3:0]  rs1_tag_i, rs2_tag_i;
  logic [31:0] rs1_value_i, rs2_value_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_value_i;
  logic        alu_request_o;
  logic [31:0] alu_pc_o, alu_inst_o, alu_rs1_value_o, alu_rs2_value_o;
  logic        alu_writeback_valid_i;
  logic [31:0] alu_writeback_value_i;
  logic        result_valid_o;
  logic [3:0]  result_tag_o;
  logic [31:0] result_value_o;
  logic        result_ready_i;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .dispatch_valid_i(dispatch_valid_i),
    .dispatch_ready_o(dispatch_ready_o),
    .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
    .dispatch_tag_i(dispatch_tag_i),
    .rs1_ready_i(rs1_ready_i), .rs2_ready_i(rs2_ready_i),
    .rs1_tag_i(rs1_tag_i), .rs2_tag_i(rs2_tag_i),
    .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
    .cdb_value_i(cdb_value_i),
    .alu_request_o(alu_request_o), .alu_pc_o(alu_pc_o),
    .alu_inst_o(alu_inst_o), .alu_rs1_value_o(alu_rs1_value_o),
    .alu_rs2_value_o(alu_rs2_value_o),
    .alu_writeback_valid_i(alu_writeback_valid_i),
    .alu_writeback_value_i(alu_writeback_value_i),
    .result_valid_o(result_valid_o), .result_tag_o(result_tag_o),
    .result_value_o(result_value_o), .result_ready_i(result_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_fn(logic [31:0] inst,
                                         logic [31:0] a, logic [31:0] b);
    case (inst[6:0])
      7'h13:   return a + {{20{inst[31]}}, inst[31:20]};
      7'h33:   return a + b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_writeback_value_i = alu_fn(alu_inst_o, alu_rs1_value_o,
                                        alu_rs2_value_o);
  assign alu_writeback_valid_i = alu_request_o;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  tag;
    bit          r1;
    logic [3:0]  t1;
    logic [31:0] v1;
    bit          r2;
    logic [3:0]  t2;
    logic [31:0] v2;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_rv;
  logic [3:0]  m_rt;
  logic [31:0] m_rval;

  // check outputs against the model, then advance it across the edge
  task automatic model_step();
    int          idx;
    bit          iss, drdy;
    logic [31:0] epc, einst, ev1, ev2;
    m_ent_t      e;
    idx = -1;
    for (int i = 0; i < mq.size(); i++)
      if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
    iss  = (idx >= 0) && !flush_i && (!m_rv || result_ready_i);
    drdy = mq.size() < DEPTH;
    epc = 0; einst = 0; ev1 = 0; ev2 = 0;
    if (iss) begin
      epc = mq[idx].pc; einst = mq[idx].inst;
      ev1 = mq[idx].v1; ev2 = mq[idx].v2;
    end
    chk("req", alu_request_o, iss);
    chk("drdy", dispatch_ready_o, drdy);
    chk("alu_pc", alu_pc_o, epc);
    chk("alu_inst", alu_inst_o, einst);
    chk("alu_rs1", alu_rs1_value_o, ev1);
    chk("alu_rs2", alu_rs2_value_o, ev2);
    chk("res_v", result_valid_o, m_rv);
    if (m_rv) begin
      chk("res_tag", result_tag_o, m_rt);
      chk("res_val", result_value_o, m_rval);
    end
    if (flush_i) begin
      mq.delete();
      m_rv = 0;
      return;
    end
    if (cdb_valid_i)
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (!e.r1 && e.t1 == cdb_tag_i) begin e.r1 = 1; e.v1 = cdb_value_i; end
        if (!e.r2 && e.t2 == cdb_tag_i) begin e.r2 = 1; e.v2 = cdb_value_i; end
        mq[i] = e;
      end
    if (iss) begin
      m_rv   = 1;
      m_rt   = mq[idx].tag;
      m_rval = alu_fn(mq[idx].inst, mq[idx].v1, mq[idx].v2);
      mq.delete(idx);
    end else if (result_ready_i) begin
      m_rv = 0;
    end
    if (dispatch_valid_i && drdy) begin
      e.pc = dispatch_pc_i; e.inst = dispatch_inst_i;
      e.tag = dispatch_tag_i;
      e.t1 = rs1_tag_i; e.t2 = rs2_tag_i;
      e.r1 = rs1_ready_i || (cdb_valid_i && cdb_tag_i == rs1_tag_i);
      e.v1 = rs1_ready_i ? rs1_value_i : cdb_value_i;
      e.r2 = rs2_ready_i || (cdb_valid_i && cdb_tag_i == rs2_tag_i);
      e.v2 = rs2_ready_i ? rs2_value_i : cdb_value_i;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; dispatch_valid_i = 0; result_ready_i = 1;
    dispatch_pc_i = 0; dispatch_inst_i = 0; dispatch_tag_i = 0;
    rs1_ready_i = 0; rs2_ready_i = 0; rs1_tag_i = 0; rs2_tag_i = 0;
    rs1_value_i = 0; rs2_value_i = 0;
    cdb_valid_i = 0; cdb_tag_i = 0; cdb_value_i = 0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [3:0] tag,
                      input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [3:0] t2);
    idle();
    dispatch_valid_i = 1; dispatch_pc_i = pc; dispatch_inst_i = inst;
    dispatch_tag_i = tag;
    rs1_ready_i = r1; rs1_value_i = v1; rs1_tag_i = t1;
    rs2_ready_i = r2; rs2_value_i = v2; rs2_tag_i = t2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_drdy"}, dispatch_ready_o, 1);
    chk({tag, "_rv"}, result_valid_o, 0);
    chk({tag, "_rtag"}, result_tag_o, 0);
    chk({tag, "_rval"}, result_value_o, 0);
    chk({tag, "_req"}, alu_request_o, 0);
    chk({tag, "_pc"}, alu_pc_o, 0);
  endtask

  // asynchronous reset pulse between clock edges
  task automatic do_reset();
    #2 reset_i = 0;
    #1 chk_reset_state("async_rst");
    mq.delete();
    m_rv = 0;
    @(posedge clk_i);
    #1 reset_i = 1;
    #1;
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [6];
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67};
    flush_i          = ($urandom_range(0, 49) == 0);
    dispatch_valid_i = ($urandom_range(0, 9) < 6);
    dispatch_pc_i    = $urandom & 32'hffff_fffc;
    dispatch_inst_i  = {$urandom_range(0, 32'h1ff_ffff),
                        ops[$urandom_range(0, 5)]};
    dispatch_tag_i   = 4'($urandom);
    rs1_ready_i      = $urandom_range(0, 1) == 1;
    rs2_ready_i      = $urandom_range(0, 1) == 1;
    rs1_tag_i        = 4'($urandom_range(0, 7));
    rs2_tag_i        = 4'($urandom_range(0, 7));
    rs1_value_i      = $urandom;
    rs2_value_i      = $urandom;
    cdb_valid_i      = $urandom_range(0, 1) == 1;
    cdb_tag_i        = 4'($urandom_range(0, 7));
    cdb_value_i      = $urandom;
    result_ready_i   = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    reset_i = 0;
    idle();
    m_rv = 0; m_rt = 0; m_rval = 0;
    #8 chk_reset_state("por");
    #4 reset_i = 1;
    @(posedge clk_i);
    #1;

    // ADDI 5+3 -> tag 2 value 8
    disp(32'h1000, 32'h0030_8113, 4'd2, 1, 5, 0, 1, 0, 0);
    tick();
    idle();
    #1 chk("addi_req", alu_request_o, 1);
    chk("addi_rv_early", result_valid_o, 0);
    tick();
    idle();
    #1 chk("addi_rv", result_valid_o, 1);
    chk("addi_tag", result_tag_o, 2);
    chk("addi_val", result_value_o, 8);
    tick();

    // ADD 10 + (tag 7 via CDB two cycles later)
    disp(32'h1004, 32'h0020_81b3, 4'd3, 1, 10, 0, 0, 0, 7);
    tick();
    idle();
    #1 chk("add_wait1", alu_request_o, 0);
    tick();
    idle();
    cdb_valid_i = 1; cdb_tag_i = 7; cdb_value_i = 20;
    #1 chk("add_wait2", alu_request_o, 0);
    tick();
    idle();
    #1 chk("add_req", alu_request_o, 1);
    chk("add_rs2", alu_rs2_value_o, 20);
    tick();
    idle();
    #1 chk("add_val", result_value_o, 30);
    tick();

    // same ADD with the broadcast in the dispatch cycle
    disp(32'h1008, 32'h0020_81b3, 4'd4, 1, 10, 0, 0, 0, 7);
    cdb_valid_i = 1; cdb_tag_i = 7; cdb_value_i = 20;
    tick();
    idle();
    #1 chk("byp_req", alu_request_o, 1);
    chk("byp_rs2", alu_rs2_value_o, 20);
    tick();
    idle();
    #1 chk("byp_val", result_value_o, 30);
    tick();

    // fill; entries 1 and 3 wake on one broadcast
    disp(32'h100, 32'h33, 4'd1, 0, 0, 9, 1, 1, 0);
    tick();
    disp(32'h104, 32'h33, 4'd2, 0, 0, 5, 1, 2, 0);
    tick();
    disp(32'h108, 32'h33, 4'd3, 0, 0, 10, 1, 3, 0);
    tick();
    disp(32'h10c, 32'h33, 4'd4, 1, 4, 0, 0, 0, 5);
    tick();
    idle();
    cdb_valid_i = 1; cdb_tag_i = 5; cdb_value_i = 32'h55;
    #1 chk("full_drdy", dispatch_ready_o, 0);
    tick();
    idle();
    #1 chk("old_first", alu_pc_o, 32'h104);
    chk("full_drdy_iss", dispatch_ready_o, 0);
    tick();
    idle();
    #1 chk("young_next", alu_pc_o, 32'h10c);
    chk("drdy_back", dispatch_ready_o, 1);
    tick();

    // flush with three entries and a pending result
    disp(32'h110, 32'h33, 4'd6, 0, 0, 11, 1, 0, 0);
    result_ready_i = 0;
    #1 chk("pend_rv", result_valid_o, 1);
    tick();
    idle();
    flush_i = 1; result_ready_i = 0;
    #1 chk("flush_req", alu_request_o, 0);
    tick();
    idle();
    #1 chk("flush_rv", result_valid_o, 0);
    chk("flush_drdy", dispatch_ready_o, 1);
    cdb_valid_i = 1; cdb_tag_i = 9; cdb_value_i = 1;
    tick();
    idle();
    #1 chk("flush_noiss", alu_request_o, 0);
    tick();

    // backpressure: one held result, then age-ordered drain
    disp(32'h200, 32'h33, 4'd5, 1, 1, 0, 1, 1, 0);
    result_ready_i = 0;
    tick();
    disp(32'h204, 32'h33, 4'd6, 1, 2, 0, 1, 2, 0);
    result_ready_i = 0;
    tick();
    disp(32'h208, 32'h33, 4'd7, 1, 3, 0, 1, 3, 0);
    result_ready_i = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      result_ready_i = 0;
      #1 chk("bp_hold", alu_request_o, 0);
      chk("bp_rv", result_valid_o, 1);
      tick();
    end
    idle();
    #1 chk("bp_rel_req", alu_request_o, 1);
    chk("bp_rel_pc", alu_pc_o, 32'h204);
    chk("bp_held_tag", result_tag_o, 5);
    tick();
    idle();
    #1 chk("bp_next_pc", alu_pc_o, 32'h208);
    chk("bp_b_tag", result_tag_o, 6);
    tick();
    idle();
    tick();

    // async reset mid-burst
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      flush_i = 0;
      tick();
    end
    rand_inputs();
    do_reset();

    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
